// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle LEGv8 core: FSM states, opcodes, ALU ops and instruction classes.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        HALT
    } state_e;

    localparam logic [10:0] OPCODE_ADD  = 11'b10001011000;
    localparam logic [10:0] OPCODE_SUB  = 11'b11001011000;
    localparam logic [10:0] OPCODE_AND  = 11'b10001010000;
    localparam logic [10:0] OPCODE_ORR  = 11'b10101010000;
    localparam logic [10:0] OPCODE_LDUR = 11'b11111000010;
    localparam logic [10:0] OPCODE_STUR = 11'b11111000000;
    localparam logic [7:0]  OPCODE_CBZ  = 8'b10110100;
    localparam logic [5:0]  OPCODE_B    = 6'b000101;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_ORR
    } alu_op_e;

    typedef enum logic [2:0] {
        INS_RTYPE,
        INS_LDUR,
        INS_STUR,
        INS_CBZ,
        INS_B,
        INS_ILLEGAL
    } ins_class_e;

    // Opcode fields nest inside IR[31:21], so the top 11 bits suffice to classify.
    function automatic ins_class_e classify(input logic [10:0] op);
        ins_class_e c;
        c = INS_ILLEGAL;
        if (op == OPCODE_ADD || op == OPCODE_SUB || op == OPCODE_AND || op == OPCODE_ORR) begin
            c = INS_RTYPE;
        end else if (op == OPCODE_LDUR) begin
            c = INS_LDUR;
        end else if (op == OPCODE_STUR) begin
            c = INS_STUR;
        end else if (op[10:3] == OPCODE_CBZ) begin
            c = INS_CBZ;
        end else if (op[10:5] == OPCODE_B) begin
            c = INS_B;
        end
        return c;
    endfunction

    function automatic alu_op_e alu_op_of(input logic [10:0] op);
        alu_op_e a;
        case (op)
            OPCODE_SUB: a = ALU_SUB;
            OPCODE_AND: a = ALU_AND;
            OPCODE_ORR: a = ALU_ORR;
            default:    a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cpu_multicycle_if.sv
// Unified memory port: registered request/write/address/data from the core, ready and read data back.
// An access completes in any cycle with mem_request and mem_ready both high; the core holds everything until then.
interface cpu_multicycle_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  mem_request;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_ready;

    modport master (
        output mem_request, mem_write, mem_address, mem_write_data,
        input  mem_read_data, mem_ready
    );

    modport slave (
        input  mem_request, mem_write, mem_address, mem_write_data,
        output mem_read_data, mem_ready
    );
endinterface

// File: rtl/cpu_register_file.sv
// Architectural register file: two combinational reads, one synchronous write, top index hard-wired to zero.
// Synchronous active-low clear of every register.
module cpu_register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_COUNT  = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [$clog2(REG_COUNT)-1:0] raddr_a_i,
    input  logic [$clog2(REG_COUNT)-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0]        rdata_a_o,
    output logic [DATA_WIDTH-1:0]        rdata_b_o,
    input  logic                         we_i,
    input  logic [$clog2(REG_COUNT)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i
);
    localparam int AW = $clog2(REG_COUNT);
    localparam logic [AW-1:0] XZR = AW'(REG_COUNT - 1);

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && waddr_i != XZR) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == XZR) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == XZR) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle LEGv8 core on one unified memory port; FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with HALT on illegal opcode.
// Memory outputs are registered and held until mem_ready; R 5, LDUR 7, STUR 6, CBZ/B 4 cycles with no waits.
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    REG_COUNT   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    cpu_multicycle_if.master       mem,
    output logic                   halted,
    output logic [DATA_WIDTH-1:0]  pc,
    output logic [COUNT_WIDTH-1:0] retired
);
    localparam int AW = $clog2(REG_COUNT);
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    state_e                 state_q, state_d;
    logic [31:0]            ir_q, ir_d;
    logic [DATA_WIDTH-1:0]  pc_q, pc_d, opa_q, opa_d, opb_q, opb_d, imm_q, imm_d;
    logic [DATA_WIDTH-1:0]  res_q, res_d, addr_q, addr_d, wdata_q, wdata_d;
    logic                   req_q, req_d, we_q, we_d;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;

    ins_class_e             cls;
    logic [4:0]             rn_field, rb_field, rd_field;
    logic [DATA_WIDTH-1:0]  rdata_a, rdata_b, alu_res;

    assign cls      = classify(ir_q[31:21]);
    assign rn_field = ir_q[9:5];
    assign rb_field = (cls == INS_RTYPE) ? ir_q[20:16] : ir_q[4:0];
    assign rd_field = ir_q[4:0];

    cpu_register_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_rf (
        .clock     (clock),
        .reset     (reset),
        .raddr_a_i (rn_field[AW-1:0]),
        .raddr_b_i (rb_field[AW-1:0]),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b),
        .we_i      (state_q == WRITEBACK),
        .waddr_i   (rd_field[AW-1:0]),
        .wdata_i   (res_q)
    );

    always_comb begin
        alu_res = '0;
        unique case (alu_op_of(ir_q[31:21]))
            ALU_ADD: alu_res = opa_q + opb_q;
            ALU_SUB: alu_res = opa_q - opb_q;
            ALU_AND: alu_res = opa_q & opb_q;
            ALU_ORR: alu_res = opa_q | opb_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        imm_d     = imm_q;
        res_d     = res_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        req_d     = req_q;
        we_d      = we_q;
        retired_d = retired_q;
        unique case (state_q)
            FETCH: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                end else if (mem.mem_ready) begin
                    req_d   = 1'b0;
                    ir_d    = mem.mem_read_data[31:0];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                opa_d = rdata_a;
                opb_d = rdata_b;
                unique case (cls)
                    INS_LDUR, INS_STUR: imm_d = {{(DATA_WIDTH-9){ir_q[20]}}, ir_q[20:12]};
                    INS_CBZ:            imm_d = {{(DATA_WIDTH-21){ir_q[23]}}, ir_q[23:5], 2'b00};
                    INS_B:              imm_d = {{(DATA_WIDTH-28){ir_q[25]}}, ir_q[25:0], 2'b00};
                    default:            imm_d = '0;
                endcase
                state_d = (cls == INS_ILLEGAL) ? HALT : EXECUTE;
            end
            EXECUTE: begin
                unique case (cls)
                    INS_RTYPE: begin
                        res_d   = alu_res;
                        state_d = WRITEBACK;
                    end
                    INS_LDUR, INS_STUR: begin
                        addr_d  = opa_q + imm_q;
                        wdata_d = opb_q;
                        state_d = MEMORY;
                    end
                    INS_CBZ: begin
                        pc_d      = (opb_q == '0) ? pc_q + imm_q : pc_q + PC_STEP;
                        retired_d = retired_q + COUNT_WIDTH'(1);
                        state_d   = FETCH;
                    end
                    INS_B: begin
                        pc_d      = pc_q + imm_q;
                        retired_d = retired_q + COUNT_WIDTH'(1);
                        state_d   = FETCH;
                    end
                    default: state_d = HALT;
                endcase
            end
            MEMORY: begin
                if (!req_q) begin
                    req_d = 1'b1;
                    we_d  = (cls == INS_STUR);
                end else if (mem.mem_ready) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (cls == INS_STUR) begin
                        pc_d      = pc_q + PC_STEP;
                        retired_d = retired_q + COUNT_WIDTH'(1);
                        state_d   = FETCH;
                    end else begin
                        res_d   = mem.mem_read_data;
                        state_d = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                pc_d      = pc_q + PC_STEP;
                retired_d = retired_q + COUNT_WIDTH'(1);
                state_d   = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // Reset discards any in-flight access and every partial result of the current instruction.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            pc_q      <= RESET_PC;
            opa_q     <= '0;
            opb_q     <= '0;
            imm_q     <= '0;
            res_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            imm_q     <= imm_d;
            res_q     <= res_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            req_q     <= req_d;
            we_q      <= we_d;
            retired_q <= retired_d;
        end
    end

    assign mem.mem_request    = req_q;
    assign mem.mem_write      = we_q;
    assign mem.mem_address    = addr_q;
    assign mem.mem_write_data = wdata_q;
    assign halted             = (state_q == HALT);
    assign pc                 = pc_q;
    assign retired            = retired_q;

endmodule
